wb_mux_bridge: RTL and testbench

- Wishbone responder that gives the management SoC control of the design-select mux, alongside the pad path.
- Holds SEL/IN registers; when WB mode is set, these drive the mux instead of the pads.
- Synchronises the mux output into a readable register and counts its changes, with an optional change interrupt.
- Sits between the Caravel Wishbone port, the pad-side sel/in wires and the shared mux.

---
 rtl/wb_mux_pkg.sv | 29 ++
 rtl/sync2.sv | 28 ++
 rtl/wb_mux_bridge.sv | 156 +++++++++++++++
 tb/tb_wb_mux_bridge.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_pkg.sv
// Shared constants for the Wishbone mux bridge: register byte offsets,
// CTRL bit positions, STATUS layout and a byte-enable merge helper.
package wb_mux_pkg;

  // Register byte offsets within the 256-byte window.
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_SEL    = 8'h04;
  localparam logic [7:0] REG_IN     = 8'h08;
  localparam logic [7:0] REG_OUT    = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;

  // CTRL bit positions.
  localparam int CTRL_WB_MODE = 0;
  localparam int CTRL_IRQ_EN  = 1;

  // STATUS layout: change counter in the low half, sticky flag above it.
  localparam int CHG_CNT_BITS = 16;
  localparam int STICKY_BIT   = 16;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a bus that is asynchronous to clk.
// Each bit is synchronised independently; no coherency across bits.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/wb_mux_bridge.sv
// Wishbone responder that lets the management SoC drive the design-select
// mux (SEL/IN registers) instead of the pads, reads back the synchronised
// mux output and counts its changes.
// Optional macro WB_MUX_IRQ_EN: implements CTRL.IRQ_EN and the irq output;
// when undefined IRQ_EN reads 0 and irq is tied low.
module wb_mux_bridge
  import wb_mux_pkg::*;
#(
  parameter int          SEL_BITS    = 6,
  parameter int          INPUT_BITS  = 12,
  parameter int          OUTPUT_BITS = 15,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [SEL_BITS-1:0]    pin_sel,
  input  logic [INPUT_BITS-1:0]  pin_in,
  output logic [SEL_BITS-1:0]    sel,
  output logic [INPUT_BITS-1:0]  in,
  input  logic [OUTPUT_BITS-1:0] out,
  output logic                   irq
);

`ifdef WB_MUX_IRQ_EN
  localparam logic [1:0] CTRL_MASK = 2'b11;
`else
  localparam logic [1:0] CTRL_MASK = 2'b01;
`endif

  logic                    ack_reg;
  logic [31:0]             dat_reg;
  logic [1:0]              ctrl_reg;
  logic [SEL_BITS-1:0]     sel_reg;
  logic [INPUT_BITS-1:0]   in_reg;
  logic [CHG_CNT_BITS-1:0] chg_cnt_reg, chg_cnt_next;
  logic                    sticky_reg, sticky_next;
  logic [OUTPUT_BITS-1:0]  out_sync, out_prev_reg;
  logic                    hit, req, wr_en, status_clr, change;
  logic [7:0]              offset;
  logic [31:0]             rdata;
  logic                    unused_adr_lsbs;

  assign unused_adr_lsbs = &{1'b0, wbs_adr_i[1:0]};

  // A request is only accepted while no ack is outstanding, so a held strobe
  // is acknowledged every second cycle. The write itself lands on the edge
  // that ends the ack cycle, and only if the master still presents it.
  assign hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req        = wbs_stb_i & wbs_cyc_i & hit & ~ack_reg;
  assign offset     = {wbs_adr_i[7:2], 2'b00};
  assign wr_en      = ack_reg & wbs_stb_i & wbs_cyc_i & wbs_we_i & hit;
  assign status_clr = wr_en && (offset == REG_STATUS);
  assign change     = (out_sync != out_prev_reg);

  sync2 #(.WIDTH(OUTPUT_BITS)) u_out_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out),
    .q     (out_sync)
  );

  // Read data mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      REG_CTRL:   rdata = 32'(ctrl_reg);
      REG_SEL:    rdata = 32'(sel_reg);
      REG_IN:     rdata = 32'(in_reg);
      REG_OUT:    rdata = 32'(out_sync);
      REG_STATUS: rdata = 32'({sticky_reg, chg_cnt_reg});
      default:    rdata = '0;
    endcase
  end

  // Single-cycle ack; read data is captured with the request and is zero
  // whenever ack is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= req;
      dat_reg <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  // Byte-enabled writes to the control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg <= '0;
      sel_reg  <= '0;
      in_reg   <= '0;
    end else if (wr_en) begin
      case (offset)
        REG_CTRL: ctrl_reg <= 2'(byte_merge(32'(ctrl_reg), wbs_dat_i, wbs_sel_i)) & CTRL_MASK;
        REG_SEL:  sel_reg  <= SEL_BITS'(byte_merge(32'(sel_reg), wbs_dat_i, wbs_sel_i));
        REG_IN:   in_reg   <= INPUT_BITS'(byte_merge(32'(in_reg), wbs_dat_i, wbs_sel_i));
        default:  ;
      endcase
    end
  end

  // Change counter: a STATUS write clears first, then a same-cycle change
  // is still counted. The counter saturates rather than wrapping.
  always_comb begin
    chg_cnt_next = status_clr ? '0 : chg_cnt_reg;
    sticky_next  = status_clr ? 1'b0 : sticky_reg;
    if (change) begin
      if (chg_cnt_next != '1) chg_cnt_next = chg_cnt_next + 1'b1;
      sticky_next = 1'b1;
    end
  end

  // Output history and change-count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prev_reg <= '0;
      chg_cnt_reg  <= '0;
      sticky_reg   <= 1'b0;
    end else begin
      out_prev_reg <= out_sync;
      chg_cnt_reg  <= chg_cnt_next;
      sticky_reg   <= sticky_next;
    end
  end

`ifdef WB_MUX_IRQ_EN
  logic irq_reg;

  // Registered interrupt: sticky change flag gated by IRQ_EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_reg <= 1'b0;
    else        irq_reg <= sticky_reg & ctrl_reg[CTRL_IRQ_EN];
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  // Mux drive is combinational from the registers so the pad path has no
  // added latency.
  assign sel       = ctrl_reg[CTRL_WB_MODE] ? sel_reg : pin_sel;
  assign in        = ctrl_reg[CTRL_WB_MODE] ? in_reg  : pin_in;
  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_mux_bridge.sv
// Directed self-checking bench for wb_mux_bridge.
module tb_wb_mux_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_MUX_IRQ_EN
  localparam logic        EXP_IRQ   = 1'b1;
  localparam logic [31:0] EXP_CTRL3 = 32'h3;
`else
  localparam logic        EXP_IRQ   = 1'b0;
  localparam logic [31:0] EXP_CTRL3 = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [5:0]  pin_sel = '0;
  logic [11:0] pin_in = '0;
  logic [5:0]  sel;
  logic [11:0] in_bus;
  logic [14:0] mux_out = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mux_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .pin_sel   (pin_sel),
    .pin_in    (pin_in),
    .sel       (sel),
    .in        (in_bus),
    .out       (mux_out),
    .irq       (irq)
  );

  // One bus transfer: waits up to 8 cycles for ack, reports latency and
  // whether ack was still high one cycle later.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] be, output logic [31:0] rdat, output logic acked,
                         output int lat, output logic ack_after);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = be;
    acked = 1'b0; lat = 0; rdat = '0; ack_after = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        acked = 1'b1; lat = i; rdat = wbs_dat_o;
        break;
      end
    end
    if (acked) begin
      @(posedge clk); #1;
      ack_after = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    $display("wb %s adr=%08h wdat=%08h be=%b -> acked=%0b lat=%0d rdat=%08h",
             we ? "WR" : "RD", adr, wdat, be, acked, lat, rdat);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] be);
    logic [31:0] r; logic a; int l; logic aa;
    wb_xfer(1'b1, adr, wdat, be, r, a, l, aa);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    logic a; int l; logic aa;
    wb_xfer(1'b0, adr, '0, 4'hF, rdat, a, l, aa);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    pin_sel = 6'h15; pin_in = 12'hABC;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%08h irq=%b, want 0/0/0", wbs_ack_o, wbs_dat_o, irq);
    end
    checks++;
    if (sel !== 6'h15 || in_bus !== 12'hABC) begin
      errors++;
      $display("FAIL reset_pad_path: sel=%h in=%h, want 15/abc", sel, in_bus);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pad_path;
    logic [31:0] r;
    wb_read(BASE + 32'h00, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL ctrl_reset: got %08h want 0", r); end
    wb_read(BASE + 32'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL status_reset: got %08h want 0", r); end
  endtask

  task automatic test_wb_mode;
    logic [31:0] r; logic a, aa; int l;
    wb_xfer(1'b1, BASE + 32'h04, 32'h2A, 4'hF, r, a, l, aa);
    checks++;
    if (a !== 1'b1 || l != 1 || aa !== 1'b0) begin
      errors++; $display("FAIL ack_width_sel: acked=%b lat=%0d after=%b, want 1/1/0", a, l, aa);
    end
    wb_xfer(1'b1, BASE + 32'h08, 32'h123, 4'hF, r, a, l, aa);
    checks++;
    if (a !== 1'b1 || l != 1 || aa !== 1'b0) begin
      errors++; $display("FAIL ack_width_in: acked=%b lat=%0d after=%b, want 1/1/0", a, l, aa);
    end
    checks++;
    if (sel !== 6'h15 || in_bus !== 12'hABC) begin
      errors++; $display("FAIL pads_before_mode: sel=%h in=%h, want 15/abc", sel, in_bus);
    end
    wb_xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF, r, a, l, aa);
    checks++;
    if (sel !== 6'h2A || in_bus !== 12'h123) begin
      errors++; $display("FAIL wb_mode_drive: sel=%h in=%h, want 2a/123", sel, in_bus);
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] r;
    wb_write(BASE + 32'h08, 32'h0, 4'hF);
    wb_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0001);
    wb_read(BASE + 32'h08, r);
    checks++;
    if (r !== 32'h0FF) begin errors++; $display("FAIL byte_enable: got %08h want 000000ff", r); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    pat = '0;
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat = {pat[2:0], wbs_ack_o};
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    $display("back_to_back ack pattern=%b", pat);
    checks++;
    if (pat !== 4'b1010) begin errors++; $display("FAIL back_to_back: pattern=%b want 1010", pat); end
  endtask

  task automatic test_change;
    logic [31:0] r;
    @(negedge clk); mux_out = 15'h1; wait_cycles(6);
    mux_out = 15'h3; wait_cycles(6);
    wb_read(BASE + 32'h0C, r);
    checks++;
    if (r !== 32'h3) begin errors++; $display("FAIL out_read: got %08h want 3", r); end
    wb_read(BASE + 32'h10, r);
    checks++;
    if (r !== 32'h0001_0002) begin errors++; $display("FAIL status_count: got %08h want 00010002", r); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b want 0", irq); end
    wb_write(BASE + 32'h00, 32'h3, 4'hF);
    wait_cycles(3);
    checks++;
    if (irq !== EXP_IRQ) begin errors++; $display("FAIL irq_set: got %b want %b", irq, EXP_IRQ); end
    wb_read(BASE + 32'h00, r);
    checks++;
    if (r !== EXP_CTRL3) begin errors++; $display("FAIL ctrl_readback: got %08h want %08h", r, EXP_CTRL3); end
    wb_write(BASE + 32'h10, 32'h0, 4'h0);
    wait_cycles(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    wb_read(BASE + 32'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL status_clear: got %08h want 0", r); end
  endtask

  task automatic test_saturate;
    logic [31:0] r;
    for (int i = 0; i < 66000; i++) begin
      @(negedge clk);
      mux_out = (i % 2 == 1) ? 15'h3 : 15'h2;
    end
    wait_cycles(6);
    wb_read(BASE + 32'h10, r);
    checks++;
    if (r !== 32'h0001_FFFF) begin errors++; $display("FAIL saturate: got %08h want 0001ffff", r); end
    // Change reaches the counter on the same edge the STATUS write lands.
    @(negedge clk); mux_out = 15'h5;
    wb_write(BASE + 32'h10, 32'h0, 4'hF);
    wait_cycles(6);
    wb_read(BASE + 32'h10, r);
    checks++;
    if (r !== 32'h0001_0001) begin errors++; $display("FAIL clear_vs_change: got %08h want 00010001", r); end
  endtask

  task automatic test_address;
    logic [31:0] r; logic a, aa; int l;
    wb_xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, r, a, l, aa);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL unmapped_write_ack: acked=%b want 1", a); end
    wb_xfer(1'b0, BASE + 32'h40, '0, 4'hF, r, a, l, aa);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: acked=%b data=%08h want 1/0", a, r);
    end
    wb_read(BASE + 32'h04, r);
    checks++;
    if (r !== 32'h2A) begin errors++; $display("FAIL unmapped_no_side_effect: SEL=%08h want 2a", r); end
    wb_xfer(1'b1, 32'h2000_0000, 32'h0, 4'hF, r, a, l, aa);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL miss_no_ack: acked=%b want 0", a); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h04; wbs_dat_i = 32'h3F; wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_mid_ack: ack=%b want 0", wbs_ack_o); end
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (sel !== pin_sel || irq !== 1'b0) begin
      errors++; $display("FAIL reset_mid_drive: sel=%h irq=%b want %h/0", sel, irq, pin_sel);
    end
    wb_read(BASE + 32'h04, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_mid_sel: got %08h want 0", r); end
    wb_read(BASE + 32'h00, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_mid_ctrl: got %08h want 0", r); end
  endtask

  initial begin
    test_reset;
    test_pad_path;
    test_wb_mode;
    test_byte_enable;
    test_back_to_back;
    test_change;
    test_saturate;
    test_address;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
